// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receiver.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  localparam int         SUBTICKS_PER_BIT = 8;
  localparam logic [2:0] LAST_SUBTICK     = 3'(SUBTICKS_PER_BIT - 1);
  localparam logic [2:0] SAMPLE_0         = 3'd3;
  localparam logic [2:0] SAMPLE_1         = 3'd4;
  localparam logic [2:0] SAMPLE_2         = 3'd5;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK_WAIT
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO; a push while full is accepted only if a pop frees a slot.
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  // Head is forced to zero while empty so outputs are clean straight out of reset.
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with 3-sample majority voting, runtime framing config, break
// detection and an AXI4-Stream output FIFO.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rxd,
  input  logic [15:0]                 prescale,
  input  logic [1:0]                  parity_mode,
  input  logic                        stop_bits,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        overrun_error,
  output logic                        frame_error,
  output logic                        break_detect
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs, rxs_prev_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
  assign rxs    = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= sync_d;
  end

  rx_state_e             state_q;
  logic [15:0]           pre_q, reload;
  logic [2:0]            sub_q;
  logic [3:0]            bit_cnt_q;
  logic [1:0]            samp_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            par_mode_q;
  logic                  two_stop_q, pbit_q, stop_low_q;
  logic                  push_q, overrun_q, frame_error_q, break_q;
  logic [DATA_WIDTH:0]   push_word_q;

  logic tick_end, decide, bit_done, vote, par_en, perr, any_low, last_stop;
  logic fifo_full, fifo_empty, pop;
  logic [DATA_WIDTH:0] fifo_dout;

  assign reload    = (prescale == 16'd0) ? 16'd0 : prescale - 16'd1;
  assign tick_end  = (pre_q == 16'd0);
  assign decide    = tick_end && (sub_q == SAMPLE_2);
  assign bit_done  = tick_end && (sub_q == LAST_SUBTICK);
  assign vote      = maj3(samp_q[0], samp_q[1], rxs);
  assign par_en    = (par_mode_q == PARITY_EVEN) || (par_mode_q == PARITY_ODD);
  assign perr      = par_en && (((^data_q) ^ pbit_q) != (par_mode_q == PARITY_ODD));
  assign any_low   = stop_low_q || !vote;
  assign last_stop = !two_stop_q || (bit_cnt_q == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RX_IDLE;
      rxs_prev_q    <= 1'b1;
      pre_q         <= '0;
      sub_q         <= '0;
      bit_cnt_q     <= '0;
      samp_q        <= '0;
      data_q        <= '0;
      par_mode_q    <= PARITY_NONE;
      two_stop_q    <= 1'b0;
      pbit_q        <= 1'b0;
      stop_low_q    <= 1'b0;
      push_q        <= 1'b0;
      push_word_q   <= '0;
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
      break_q       <= 1'b0;
    end else begin
      rxs_prev_q    <= rxs;
      push_q        <= 1'b0;
      frame_error_q <= 1'b0;
      break_q       <= 1'b0;
      overrun_q     <= push_q && fifo_full && !pop;

      if (state_q inside {RX_START, RX_DATA, RX_PARITY, RX_STOP}) begin
        if (tick_end) begin
          pre_q <= reload;
          sub_q <= sub_q + 3'd1;
        end else begin
          pre_q <= pre_q - 16'd1;
        end
        if (tick_end && sub_q == SAMPLE_0) samp_q[0] <= rxs;
        if (tick_end && sub_q == SAMPLE_1) samp_q[1] <= rxs;
      end

      case (state_q)
        RX_IDLE: begin
          if (rxs_prev_q && !rxs) begin
            state_q    <= RX_START;
            pre_q      <= reload;
            sub_q      <= '0;
            bit_cnt_q  <= '0;
            stop_low_q <= 1'b0;
            pbit_q     <= 1'b0;
            par_mode_q <= parity_mode;
            two_stop_q <= stop_bits;
          end
        end
        RX_START: begin
          if (decide && vote) state_q <= RX_IDLE;
          else if (bit_done)  state_q <= RX_DATA;
        end
        RX_DATA: begin
          if (decide) data_q <= {vote, data_q[DATA_WIDTH-1:1]};
          if (bit_done) begin
            if (bit_cnt_q == 4'(DATA_WIDTH - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= par_en ? RX_PARITY : RX_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        RX_PARITY: begin
          if (decide)   pbit_q  <= vote;
          if (bit_done) state_q <= RX_STOP;
        end
        RX_STOP: begin
          // The whole frame is judged at the last stop bit's vote, leaving
          // the rest of that bit free for the next start edge.
          if (decide && last_stop) begin
            if (data_q == '0 && (!par_en || !pbit_q) && any_low) begin
              break_q <= 1'b1;
              state_q <= RX_BREAK_WAIT;
            end else if (any_low) begin
              frame_error_q <= 1'b1;
              state_q       <= RX_IDLE;
            end else begin
              push_q      <= 1'b1;
              push_word_q <= {perr, data_q};
              state_q     <= RX_IDLE;
            end
          end else if (decide) begin
            stop_low_q <= !vote;
          end
          if (bit_done) bit_cnt_q <= 4'd1;
        end
        RX_BREAK_WAIT: begin
          if (rxs) state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign pop = m_axis_tvalid && m_axis_tready;

  uart_sync_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_q),
    .din  (push_word_q),
    .pop  (pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign {m_axis_tuser, m_axis_tdata} = fifo_dout;
  assign m_axis_tvalid = !fifo_empty;
  assign busy          = (state_q != RX_IDLE);
  assign overrun_error = overrun_q;
  assign frame_error   = frame_error_q;
  assign break_detect  = break_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed and randomized frames checked against a frame-level reference model.
module tb_uart_rx_ext;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic        clk = 1'b0, rst = 1'b1, rxd = 1'b1;
  logic [15:0] prescale = 16'd1;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop_bits = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic        m_axis_tuser, m_axis_tvalid, m_axis_tready = 1'b0;
  logic [4:0]  fifo_count;
  logic        busy, overrun_error, frame_error, break_detect;

  uart_rx_ext #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .prescale(prescale), .parity_mode(parity_mode),
    .stop_bits(stop_bits), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .fifo_count(fifo_count),
    .busy(busy), .overrun_error(overrun_error), .frame_error(frame_error),
    .break_detect(break_detect)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int n_ovr = 0, n_fe = 0, n_brk = 0, hold_viol = 0;
  int exp_ovr = 0, exp_fe = 0, exp_brk = 0, exp_pending = 0;
  bit blocked = 0, rnd_ready = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  logic       pv = 1'b0, pr = 1'b0;
  logic [8:0] pw = '0;

  // Observe at the falling edge: a beat seen here is popped at the next rising edge.
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tuser, m_axis_tdata});
    if (overrun_error) n_ovr <= n_ovr + 1;
    if (frame_error)   n_fe  <= n_fe + 1;
    if (break_detect)  n_brk <= n_brk + 1;
    if (pv && !pr && m_axis_tvalid && {m_axis_tuser, m_axis_tdata} !== pw) hold_viol <= hold_viol + 1;
    pv <= m_axis_tvalid;
    pr <= m_axis_tready;
    pw <= {m_axis_tuser, m_axis_tdata};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bit(input logic v, input int glitch_at);
    int n = 8 * ((prescale == 16'd0) ? 1 : int'(prescale));
    for (int i = 0; i < n; i++) begin
      rxd = (i == glitch_at) ? ~v : v;
      tick();
    end
    rxd = v;
  endtask

  // Reference: outcome of one frame derived from its bit contents alone.
  task automatic model(input logic [7:0] d, input logic pb, input logic s1, input logic s2);
    bit pen = (parity_mode == 2'b01) || (parity_mode == 2'b10);
    bit bad = !s1 || (stop_bits && !s2);
    if (d == 8'h00 && (!pen || !pb) && bad) exp_brk++;
    else if (bad) exp_fe++;
    else if (blocked && exp_pending >= DEPTH) exp_ovr++;
    else begin
      exp_q.push_back({1'(pen && ((^d ^ pb) != (parity_mode == 2'b10))), d});
      if (blocked) exp_pending++;
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ (parity_mode == 2'b10);
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic pb, input logic s1, input logic s2,
                            input int glitch_bit);
    model(d, pb, s1, s2);
    send_bit(1'b0, -1);
    for (int b = 0; b < DW; b++)
      send_bit(d[b], (b == glitch_bit) ? 4 * int'(prescale) : -1);
    if (parity_mode == 2'b01 || parity_mode == 2'b10) send_bit(pb, -1);
    send_bit(s1, -1);
    if (stop_bits) send_bit(s2, -1);
    send_bit(1'b1, -1);
    send_bit(1'b1, -1);
  endtask

  task automatic drain();
    int t = 0;
    rnd_ready = 0;
    m_axis_tready = 1'b1;
    while (fifo_count != 5'd0 && t < 300) begin
      tick();
      t++;
    end
    repeat (3) tick();
    check("drain_empty", 32'(fifo_count), 32'd0);
    blocked = 0;
    exp_pending = 0;
  endtask

  task automatic compare_words(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_pulses(input string tag);
    check({tag, "_overrun"}, n_ovr, exp_ovr);
    check({tag, "_frame_err"}, n_fe, exp_fe);
    check({tag, "_break"}, n_brk, exp_brk);
  endtask

  initial begin
    logic [7:0] d;
    logic       pb, s1, s2;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", {13'd0, m_axis_tdata, m_axis_tuser, m_axis_tvalid, fifo_count,
                            busy, overrun_error, frame_error, break_detect}, 32'd0);
    rst = 1'b0;
    repeat (4) tick();
    check("idle_busy", 32'(busy), 32'd0);

    // 8N1 0xA5 at prescale 1
    m_axis_tready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, -1);
    drain();
    check("a5_direct", got_q.size() == 1 ? 32'(got_q[0]) : 32'hDEAD, 32'h0A5);
    compare_words("a5");
    compare_pulses("a5");

    // 8E1 with wrong parity, then 8O2 with a low second stop bit
    parity_mode = 2'b01;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, -1);
    drain();
    check("even_perr_direct", got_q.size() == 1 ? 32'(got_q[0]) : 32'hDEAD, 32'h103);
    compare_words("even_perr");
    parity_mode = 2'b10;
    stop_bits = 1'b1;
    send_frame(8'h3C, good_par(8'h3C), 1'b1, 1'b0, -1);
    drain();
    compare_words("odd_stop2");
    compare_pulses("odd_stop2");

    // Single-cycle glitch in data bit 2, then a short low pulse on an idle line
    parity_mode = 2'b00;
    stop_bits = 1'b0;
    prescale = 16'd4;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 2);
    rxd = 1'b0;
    tick();
    tick();
    rxd = 1'b1;
    repeat (4) send_bit(1'b1, -1);
    check("glitch_busy", 32'(busy), 32'd0);
    drain();
    compare_words("glitch");
    compare_pulses("glitch");

    // Overrun: 17 frames with the consumer stalled
    prescale = 16'd1;
    m_axis_tready = 1'b0;
    blocked = 1;
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b1, -1);
    check("full_count", 32'(fifo_count), 32'(DEPTH));
    check("overrun_pulses", n_ovr, 1);
    drain();
    compare_words("overrun");
    compare_pulses("overrun");

    // Break: line low for two frame times, then a normal frame
    rxd = 1'b0;
    repeat (160) tick();
    exp_brk++;
    rxd = 1'b1;
    send_bit(1'b1, -1);
    send_bit(1'b1, -1);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, -1);
    drain();
    compare_words("break");
    compare_pulses("break");

    // Reset mid-frame with three words buffered
    m_axis_tready = 1'b0;
    blocked = 1;
    for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(1, 255)), 1'b0, 1'b1, 1'b1, -1);
    check("rst_pre_count", 32'(fifo_count), 32'd3);
    send_bit(1'b0, -1);
    for (int b = 0; b < 3; b++) send_bit(1'b1, -1);
    @(negedge clk);
    check("rst_pre_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rxd = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_after", {29'd0, m_axis_tvalid, |fifo_count, busy}, 32'd0);
    exp_q.delete();
    blocked = 0;
    exp_pending = 0;
    repeat (4) tick();
    m_axis_tready = 1'b1;
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, -1);
    drain();
    compare_words("rst_recover");
    compare_pulses("rst_recover");

    // Randomized frames with random config and random consumer stalls
    for (int f = 0; f < 24; f++) begin
      prescale    = 16'($urandom_range(0, 3));
      parity_mode = 2'($urandom_range(0, 3));
      stop_bits   = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      pb = good_par(d) ^ ($urandom_range(0, 9) < 3);
      s1 = ($urandom_range(0, 9) > 1);
      s2 = ($urandom_range(0, 9) > 1);
      rnd_ready = 1;
      send_frame(d, pb, s1, s2, -1);
    end
    drain();
    compare_words("random");
    compare_pulses("random");
    check("hold_stable", hold_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
